// File: rtl/i2s_frame_sched.sv
// i2s_frame_sched: frame-rate scheduler between an I2S receiver/transmitter pair
// and a sample-processing chain, all clocked by the I2S bit clock.
//
// Each ws_in falling edge is a frame tick. On a tick the receiver pair is
// captured and offered downstream (valid/ready). Processed pairs are queued in
// a small FIFO. One queued pair is released to the transmitter per tick once
// the FIFO has been primed. An empty FIFO at a tick reports underflow and
// re-primes the FIFO.
//
// Ports:
//   sclk_in                      bit clock, rising edge
//   rst                          synchronous reset, active-high
//   ws_in                        I2S word select
//   rx_left/rx_right             received pair, stable at the frame tick
//   proc_in_valid/ready/left/right   captured pair offered downstream
//   proc_out_valid/ready/left/right  processed pair pushed into the FIFO
//   tx_left/tx_right             pair driven to the transmitter
//   underflow                    1-cycle pulse: tick while running with an empty FIFO
//   overrun                      1-cycle pulse: pending offer overwritten by a new pair
//
// Build option I2S_SCHED_STATS_EN: adds saturating 16-bit counters
// underflow_cnt and overrun_cnt of the two pulses.
module i2s_frame_sched #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PRIME_LEVEL = 2
) (
  input  logic             sclk_in,
  input  logic             rst,
  input  logic             ws_in,
  input  logic [WIDTH-1:0] rx_left,
  input  logic [WIDTH-1:0] rx_right,
  output logic             proc_in_valid,
  input  logic             proc_in_ready,
  output logic [WIDTH-1:0] proc_in_left,
  output logic [WIDTH-1:0] proc_in_right,
  input  logic             proc_out_valid,
  output logic             proc_out_ready,
  input  logic [WIDTH-1:0] proc_out_left,
  input  logic [WIDTH-1:0] proc_out_right,
  output logic [WIDTH-1:0] tx_left,
  output logic [WIDTH-1:0] tx_right,
`ifdef I2S_SCHED_STATS_EN
  output logic             underflow,
  output logic             overrun,
  output logic [15:0]      underflow_cnt,
  output logic [15:0]      overrun_cnt
`else
  output logic             underflow,
  output logic             overrun
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] PrimeC = CntW'(PRIME_LEVEL);

  typedef enum logic {InIdle, InOffer} in_state_e;
  typedef enum logic {OutPrime, OutRun} out_state_e;

  // Frame tick detection
  logic ws_q, ws_d;
  logic frame_tick;

  // Input side
  in_state_e        in_state_q, in_state_d;
  logic [WIDTH-1:0] pil_q, pil_d;
  logic [WIDTH-1:0] pir_q, pir_d;
  logic             overrun_q, overrun_d;

  // Output FIFO
  logic [2*WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               full;
  logic               push;
  logic               pop;

  // Output side
  out_state_e         out_state_q, out_state_d;
  logic [2*WIDTH-1:0] tx_q, tx_d;
  logic               underflow_q, underflow_d;

  assign ws_d       = ws_in;
  assign frame_tick = ws_q & ~ws_in;

  // Input FSM: a tick always loads the new pair; it is an overrun only when
  // the pending pair is not being accepted on that same edge.
  always_comb begin
    in_state_d = in_state_q;
    pil_d      = pil_q;
    pir_d      = pir_q;
    overrun_d  = 1'b0;
    unique case (in_state_q)
      InIdle: begin
        if (frame_tick) begin
          pil_d      = rx_left;
          pir_d      = rx_right;
          in_state_d = InOffer;
        end
      end
      InOffer: begin
        if (frame_tick) begin
          pil_d     = rx_left;
          pir_d     = rx_right;
          overrun_d = ~proc_in_ready;
        end else if (proc_in_ready) begin
          in_state_d = InIdle;
        end
      end
      default: in_state_d = InIdle;
    endcase
  end

  assign full = (count_q == DepthC);
  assign push = proc_out_valid & ~full;

  // Output FSM: priming is judged on the registered count, so the switch to
  // run takes effect one cycle after the count reaches the prime level.
  always_comb begin
    out_state_d = out_state_q;
    tx_d        = tx_q;
    underflow_d = 1'b0;
    pop         = 1'b0;
    unique case (out_state_q)
      OutPrime: begin
        if (count_q >= PrimeC) begin
          out_state_d = OutRun;
        end
      end
      OutRun: begin
        if (frame_tick) begin
          if (count_q != '0) begin
            pop  = 1'b1;
            tx_d = mem_q[rd_ptr_q];
          end else begin
            // A push on this edge is not bypassed; it stays queued.
            underflow_d = 1'b1;
            out_state_d = OutPrime;
          end
        end
      end
      default: out_state_d = OutPrime;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sclk_in) begin
    if (rst) begin
      ws_q        <= 1'b1;
      in_state_q  <= InIdle;
      pil_q       <= '0;
      pir_q       <= '0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_state_q <= OutPrime;
      tx_q        <= '0;
      underflow_q <= 1'b0;
    end else begin
      ws_q        <= ws_d;
      in_state_q  <= in_state_d;
      pil_q       <= pil_d;
      pir_q       <= pir_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_state_q <= out_state_d;
      tx_q        <= tx_d;
      underflow_q <= underflow_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge sclk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {proc_out_left, proc_out_right};
    end
  end

`ifdef I2S_SCHED_STATS_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;
  logic [15:0] ov_cnt_q, ov_cnt_d;

  always_comb begin
    uf_cnt_d = uf_cnt_q;
    ov_cnt_d = ov_cnt_q;
    if (underflow_d && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
    if (overrun_d && (ov_cnt_q != 16'hFFFF)) begin
      ov_cnt_d = ov_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sclk_in) begin
    if (rst) begin
      uf_cnt_q <= '0;
      ov_cnt_q <= '0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
      ov_cnt_q <= ov_cnt_d;
    end
  end

  assign underflow_cnt = uf_cnt_q;
  assign overrun_cnt   = ov_cnt_q;
`endif

  assign proc_in_valid  = (in_state_q == InOffer);
  assign proc_in_left   = pil_q;
  assign proc_in_right  = pir_q;
  assign proc_out_ready = ~full;
  assign tx_left        = tx_q[2*WIDTH-1:WIDTH];
  assign tx_right       = tx_q[WIDTH-1:0];
  assign underflow      = underflow_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_i2s_frame_sched.sv
// Self-checking bench for i2s_frame_sched: a queue-based frame model compared
// against the DUT every cycle, plus literal checkpoints along directed scenarios.
module tb_i2s_frame_sched;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int PRIME = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         ws_in;
  logic [W-1:0] rx_left, rx_right;
  logic         proc_in_valid, proc_in_ready;
  logic [W-1:0] proc_in_left, proc_in_right;
  logic         proc_out_valid, proc_out_ready;
  logic [W-1:0] proc_out_left, proc_out_right;
  logic [W-1:0] tx_left, tx_right;
  logic         underflow, overrun;
`ifdef I2S_SCHED_STATS_EN
  logic [15:0]  underflow_cnt, overrun_cnt;
`endif

  // Bench-side drive of the processed-pair port, or loopback from proc_in.
  logic         loop_en;
  logic         po_valid;
  logic [W-1:0] po_left, po_right;

  assign proc_out_valid = loop_en ? (proc_in_valid & proc_in_ready) : po_valid;
  assign proc_out_left  = loop_en ? proc_in_left : po_left;
  assign proc_out_right = loop_en ? proc_in_right : po_right;

  i2s_frame_sched #(
    .WIDTH(W),
    .FIFO_DEPTH(DEPTH),
    .PRIME_LEVEL(PRIME)
  ) dut (
    .sclk_in(clk),
    .rst(rst),
    .ws_in(ws_in),
    .rx_left(rx_left),
    .rx_right(rx_right),
    .proc_in_valid(proc_in_valid),
    .proc_in_ready(proc_in_ready),
    .proc_in_left(proc_in_left),
    .proc_in_right(proc_in_right),
    .proc_out_valid(proc_out_valid),
    .proc_out_ready(proc_out_ready),
    .proc_out_left(proc_out_left),
    .proc_out_right(proc_out_right),
    .tx_left(tx_left),
    .tx_right(tx_right),
`ifdef I2S_SCHED_STATS_EN
    .underflow(underflow),
    .overrun(overrun),
    .underflow_cnt(underflow_cnt),
    .overrun_cnt(overrun_cnt)
`else
    .underflow(underflow),
    .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  int uf_seen = 0;
  int ov_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: state after the next rising edge, built from the rules
  logic          m_ws_q;
  logic          m_valid;
  logic [W-1:0]  m_pil, m_pir;
  logic [31:0]   m_q[$];
  logic          m_run;
  logic [31:0]   m_tx;
  logic          m_uf, m_ov;
  logic [15:0]   m_ucnt, m_ocnt;

  task automatic model_step();
    logic tick, hs, do_push;
    int   size;
    if (rst) begin
      m_ws_q = 1'b1; m_valid = 1'b0; m_pil = '0; m_pir = '0;
      m_q.delete(); m_run = 1'b0; m_tx = '0; m_uf = 1'b0; m_ov = 1'b0;
      m_ucnt = '0; m_ocnt = '0;
    end else begin
      tick = m_ws_q && !ws_in;
      hs   = m_valid && proc_in_ready;
      m_ov = 1'b0;
      m_uf = 1'b0;
      if (tick) begin
        m_ov    = m_valid && !hs;
        m_pil   = rx_left;
        m_pir   = rx_right;
        m_valid = 1'b1;
      end else if (hs) begin
        m_valid = 1'b0;
      end
      size    = m_q.size();
      do_push = proc_out_valid && (size < DEPTH);
      if (m_run) begin
        if (tick) begin
          if (size > 0) begin
            m_tx = m_q.pop_front();
          end else begin
            m_uf  = 1'b1;
            m_run = 1'b0;
          end
        end
      end else if (size >= PRIME) begin
        m_run = 1'b1;
      end
      if (do_push) m_q.push_back({proc_out_left, proc_out_right});
      if (m_uf && m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
      if (m_ov && m_ocnt != 16'hFFFF) m_ocnt = m_ocnt + 16'd1;
      m_ws_q = ws_in;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("proc_in_valid", {31'd0, proc_in_valid}, {31'd0, m_valid});
      check("proc_in_left", {16'd0, proc_in_left}, {16'd0, m_pil});
      check("proc_in_right", {16'd0, proc_in_right}, {16'd0, m_pir});
      check("proc_out_ready", {31'd0, proc_out_ready}, {31'd0, (m_q.size() < DEPTH)});
      check("tx_pair", {tx_left, tx_right}, m_tx);
      check("underflow", {31'd0, underflow}, {31'd0, m_uf});
      check("overrun", {31'd0, overrun}, {31'd0, m_ov});
`ifdef I2S_SCHED_STATS_EN
      check("underflow_cnt", {16'd0, underflow_cnt}, {16'd0, m_ucnt});
      check("overrun_cnt", {16'd0, overrun_cnt}, {16'd0, m_ocnt});
`endif
      if (underflow === 1'b1) uf_seen++;
      if (overrun === 1'b1) ov_seen++;
    end
    model_step();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One frame: ws low for 4 cycles (tick on the first edge), then high for 4.
  task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r);
    rx_left  = l;
    rx_right = r;
    ws_in    = 1'b0;
    repeat (4) cyc();
    ws_in = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
    po_valid = 1'b1;
    po_left  = l;
    po_right = r;
    cyc();
    po_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ws_in = 1'b1; rx_left = '0; rx_right = '0;
    proc_in_ready = 1'b0; loop_en = 1'b0;
    po_valid = 1'b0; po_left = '0; po_right = '0;
    repeat (2) cyc();
    chk_en = 1'b1;
    rst    = 1'b0;
    check("reset_tx", {tx_left, tx_right}, 32'h0);
    check("reset_valid", {31'd0, proc_in_valid}, 32'h0);

    // Loopback: tx lags rx by two frames after priming
    loop_en = 1'b1; proc_in_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      frame(16'h1000 + W'(k), 16'h2000 + W'(k));
      if (k == 1) check("prime_tx_zero", {tx_left, tx_right}, 32'h0);
      if (k == 3) check("loop_tx_p1", {tx_left, tx_right}, 32'h1001_2001);
      if (k == 5) check("loop_tx_p3", {tx_left, tx_right}, 32'h1003_2003);
    end

    // Overrun: two ticks with ready low
    loop_en = 1'b0; proc_in_ready = 1'b0;
    frame(16'hA0A0, 16'hA1A1);
    frame(16'hB0B0, 16'hB1B1);
    check("ovr_left_b", {16'd0, proc_in_left}, 32'h0000_B0B0);
    check("ovr_valid", {31'd0, proc_in_valid}, 32'h1);
    check("ovr_once", ov_seen, 1);
    check("ovr_tx_p5", {tx_left, tx_right}, 32'h1005_2005);

    // Ready with tick: no overrun; FIFO empty in run gives an underflow
    rx_left = 16'hC0C0; rx_right = 16'hC1C1; ws_in = 1'b0; proc_in_ready = 1'b1;
    cyc();
    proc_in_ready = 1'b0;
    repeat (3) cyc();
    ws_in = 1'b1;
    repeat (4) cyc();
    check("hs_tick_left_c", {16'd0, proc_in_left}, 32'h0000_C0C0);
    check("hs_tick_valid", {31'd0, proc_in_valid}, 32'h1);
    check("hs_tick_no_ovr", ov_seen, 1);
    check("uf_first", uf_seen, 1);
    check("uf_tx_hold", {tx_left, tx_right}, 32'h1005_2005);

    // Re-prime and resume, then starve again
    proc_in_ready = 1'b1;
    cyc();
    push(16'h5150, 16'h5151);
    push(16'h5250, 16'h5251);
    cyc();
    frame(16'hD0D0, 16'hD1D1);
    check("resume_q0", {tx_left, tx_right}, 32'h5150_5151);
    frame(16'hD2D2, 16'hD3D3);
    frame(16'hD4D4, 16'hD5D5);
    check("uf_second", uf_seen, 2);
    check("uf_hold_q1", {tx_left, tx_right}, 32'h5250_5251);

    // Push on the same edge as an empty-FIFO tick: no bypass
    push(16'h6160, 16'h6161);
    push(16'h6260, 16'h6261);
    cyc();
    frame(16'hE0E0, 16'hE1E1);
    frame(16'hE2E2, 16'hE3E3);
    rx_left = 16'hE4E4; rx_right = 16'hE5E5; ws_in = 1'b0;
    po_valid = 1'b1; po_left = 16'h7070; po_right = 16'h7071;
    cyc();
    po_valid = 1'b0;
    repeat (3) cyc();
    ws_in = 1'b1;
    repeat (4) cyc();
    check("uf_third", uf_seen, 3);
    check("uf_nobypass_tx", {tx_left, tx_right}, 32'h6260_6261);

    // Fill to full, drop an extra push, then drain in order
    push(16'h7170, 16'h7171);
    push(16'h7270, 16'h7271);
    push(16'h7370, 16'h7371);
    check("full_ready_low", {31'd0, proc_out_ready}, 32'h0);
    push(16'h7470, 16'h7471);
    check("full_still_low", {31'd0, proc_out_ready}, 32'h0);
    frame(16'hF0F0, 16'hF1F1);
    check("pop_ready_high", {31'd0, proc_out_ready}, 32'h1);
    check("pop_r0", {tx_left, tx_right}, 32'h7070_7071);
    for (int k = 0; k < 3; k++) frame(16'hF2F2, 16'hF3F3);
    check("drain_r3", {tx_left, tx_right}, 32'h7370_7371);
    frame(16'hF4F4, 16'hF5F5);
    check("uf_fourth", uf_seen, 4);

    // Reset mid-activity with an offer pending and the FIFO non-empty
    proc_in_ready = 1'b0;
    frame(16'h9090, 16'h9191);
    push(16'h9292, 16'h9393);
`ifdef I2S_SCHED_STATS_EN
    check("stat_uf_lit", {16'd0, underflow_cnt}, 32'd4);
    check("stat_ov_lit", {16'd0, overrun_cnt}, 32'd1);
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_valid", {31'd0, proc_in_valid}, 32'h0);
    check("rst_tx", {tx_left, tx_right}, 32'h0);
    check("rst_fifo_empty", {31'd0, proc_out_ready}, 32'h1);
`ifdef I2S_SCHED_STATS_EN
    check("rst_stat_uf", {16'd0, underflow_cnt}, 32'd0);
    check("rst_stat_ov", {16'd0, overrun_cnt}, 32'd0);
`endif

    // Operation resumes from a clean state
    loop_en = 1'b1; proc_in_ready = 1'b1;
    frame(16'h3000, 16'h4000);
    frame(16'h3001, 16'h4001);
    check("post_rst_prime", {tx_left, tx_right}, 32'h0);
    frame(16'h3002, 16'h4002);
    check("post_rst_h0", {tx_left, tx_right}, 32'h3000_4000);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
